// File: rtl/bin_to_7seg_display.sv
// Multi-digit binary to active-low seven-segment driver using serial double-dabble.
// Define BIN7SEG_BLANK_EN to blank leading zero digits in the displayed result.
module bin_to_7seg_display #(
    parameter int W = 11,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   num,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic [7*N-1:0] seg
);

    // Decimal digits needed for the largest W-bit value.
    function automatic int dec_digits(input int w);
        longint unsigned v;
        int d;
        v = (64'd1 << w) - 64'd1;
        d = 1;
        v = v / 64'd10;
        while (v != 64'd0) begin
            d++;
            v = v / 64'd10;
        end
        return d;
    endfunction

    // At least one guard digit above the displayed ones, so overflow is always visible.
    localparam int ND = ((dec_digits(W) > N) ? dec_digits(W) : N) + 1;
    localparam int BW = 4 * ND;
    localparam int CW = $clog2(W + 1);

    localparam logic [6:0] SEG_ERR   = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = SEG_ERR;
        endcase
    endfunction

    function automatic logic [7*N-1:0] seg_reset();
        logic [7*N-1:0] s;
        for (int k = 0; k < N; k++) begin
`ifdef BIN7SEG_BLANK_EN
            s[7*k +: 7] = (k == 0) ? SEG_ZERO : SEG_BLANK;
`else
            s[7*k +: 7] = SEG_ZERO;
`endif
        end
        return s;
    endfunction

    localparam logic [7*N-1:0] SEG_RST = seg_reset();

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic [W-1:0]    r_bin;
    logic [BW-1:0]   r_bcd;
    logic [CW-1:0]   r_cnt;
    logic [7*N-1:0]  r_seg;
    logic            r_ovf;

    logic [BW-1:0]   w_bcd_adj;
    logic [BW-1:0]   w_bcd_shift;
    logic            w_last;
    logic            w_ovf;
    logic [7*N-1:0]  w_seg;

    assign w_last      = (r_cnt == CW'(W - 1));
    assign w_bcd_shift = {w_bcd_adj[BW-2:0], r_bin[W-1]};
    assign w_ovf       = |w_bcd_shift[BW-1:4*N];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < ND; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // Decode from the final shifted value so seg/ovf are valid in the done cycle.
    always_comb begin : p_decode
`ifdef BIN7SEG_BLANK_EN
        logic seen;
        seen = 1'b0;
`endif
        w_seg = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_seg[7*k +: 7] = w_ovf ? SEG_ERR : dec7(w_bcd_shift[4*k +: 4]);
`ifdef BIN7SEG_BLANK_EN
            if (!w_ovf && k != 0 && !seen && w_bcd_shift[4*k +: 4] == 4'd0)
                w_seg[7*k +: 7] = SEG_BLANK;
            if (w_bcd_shift[4*k +: 4] != 4'd0)
                seen = 1'b1;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_seg   <= SEG_RST;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin <= num;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_shift;
                    r_bin <= {r_bin[W-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_seg <= w_seg;
                        r_ovf <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign ovf  = r_ovf;
    assign seg  = r_seg;

endmodule

// File: tb/tb_bin_to_7seg_display.sv
// Self-checking bench: two instances (N=4 and N=3, W=11) against a decimal reference model.
module tb_bin_to_7seg_display;

    localparam int W      = 11;
    localparam int BUDGET = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] num4 = '0, num3 = '0;
    logic start4 = 1'b0, start3 = 1'b0;
    logic busy4, done4, ovf4, busy3, done3, ovf3;
    logic [27:0] seg4;
    logic [20:0] seg3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin_to_7seg_display #(.W(W), .N(4)) dut4 (
        .clk(clk), .rst(rst), .num(num4), .start(start4),
        .busy(busy4), .done(done4), .ovf(ovf4), .seg(seg4)
    );

    bin_to_7seg_display #(.W(W), .N(3)) dut3 (
        .clk(clk), .rst(rst), .num(num3), .start(start3),
        .busy(busy3), .done(done3), .ovf(ovf3), .seg(seg3)
    );

    localparam logic [6:0] PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    // Reference: decimal digits by division, overflow by comparison with 10^n.
    function automatic logic [63:0] model_seg(input int unsigned v, input int n);
        logic [63:0] r;
        int unsigned p;
        int unsigned lim;
        r = '0;
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        p = 1;
        for (int k = 0; k < n; k++) begin
            logic [6:0] d;
            if (v >= lim) d = 7'b0011000;
            else begin
                d = PAT[(v / p) % 10];
`ifdef BIN7SEG_BLANK_EN
                if (k > 0 && v < p) d = 7'b1111111;
`endif
            end
            r[7*k +: 7] = d;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v, input int n);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cur_seg(input bit on3);
        return on3 ? 64'(seg3) : 64'(seg4);
    endfunction

    // Called at a negedge; start is sampled on the following posedge.
    task automatic run_conv(input bit on3, input int unsigned v, input int restart_at,
                            input int unsigned restart_v, output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        if (on3) begin start3 = 1'b1; num3 = W'(v); end
        else     begin start4 = 1'b1; num4 = W'(v); end
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            start4 = 1'b0;
            if (c == restart_at) begin
                if (on3) begin start3 = 1'b1; num3 = W'(restart_v); end
                else     begin start4 = 1'b1; num4 = W'(restart_v); end
            end
            if (on3 ? busy3 : busy4) nbusy++;
            if (on3 ? done3 : done4) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic conv_check(input string tag, input bit on3, input int unsigned v,
                              input int restart_at, input int unsigned restart_v);
        int lat, nbusy, n;
        n = on3 ? 3 : 4;
        run_conv(on3, v, restart_at, restart_v, lat, nbusy);
        check({tag, " latency"}, 64'(lat), 64'(W + 1));
        check({tag, " busy_len"}, 64'(nbusy), 64'(W + 1));
        check({tag, " seg"}, cur_seg(on3), model_seg(v, n));
        check({tag, " ovf"}, 64'(on3 ? ovf3 : ovf4), 64'(model_ovf(v, n)));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'({on3 ? done3 : done4, on3 ? busy3 : busy4}), 64'd0);
    endtask

    initial begin
        int lat, nbusy, ndone;
        int unsigned v;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst busy4/done4/ovf4", 64'({busy4, done4, ovf4}), 64'd0);
        check("rst busy3/done3/ovf3", 64'({busy3, done3, ovf3}), 64'd0);
        check("rst seg4", 64'(seg4), model_seg(0, 4));
        check("rst seg3", 64'(seg3), model_seg(0, 3));

        // Directed values including full-scale and the overflow boundary
        conv_check("n4 2047", 1'b0, 2047, 0, 0);
        conv_check("n4 0", 1'b0, 0, 0, 0);
        conv_check("n4 7", 1'b0, 7, 0, 0);
        conv_check("n4 1000", 1'b0, 1000, 0, 0);
        conv_check("n3 1000", 1'b1, 1000, 0, 0);
        conv_check("n3 999", 1'b1, 999, 0, 0);

        // A start during busy is ignored along with the new num
        conv_check("n4 restart", 1'b0, 5, 3, 8);

        // start held on the done cycle is ignored
        run_conv(1'b0, 321, 0, 0, lat, nbusy);
        check("done-start latency", 64'(lat), 64'(W + 1));
        start4 = 1'b1;
        num4 = W'(99);
        @(negedge clk);
        start4 = 1'b0;
        check("done-start ignored busy", 64'(busy4), 64'd0);
        repeat (3) @(negedge clk);
        check("hold seg", 64'(seg4), model_seg(321, 4));

        // Reset in mid-conversion discards the result
        start4 = 1'b1;
        num4 = W'(1234);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start4 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done4) ndone++;
            if (c == 0) begin
                check("mid-rst busy/ovf", 64'({busy4, ovf4}), 64'd0);
                check("mid-rst seg", 64'(seg4), model_seg(0, 4));
            end
            @(negedge clk);
        end
        check("mid-rst no done", 64'(ndone), 64'd0);
        conv_check("n4 42 after rst", 1'b0, 42, 0, 0);

        // Randomized values, back-to-back
        for (int i = 0; i < 12; i++) begin
            v = $urandom_range(0, 2047);
            conv_check($sformatf("n4 rnd %0d", v), 1'b0, v, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            v = $urandom_range(0, 2047);
            conv_check($sformatf("n3 rnd %0d", v), 1'b1, v, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_to_7seg_display.md
# bin_to_7seg_display

Parametrised multi-digit binary-to-seven-segment display driver. Converts an unsigned W-bit binary value to N BCD digits using a sequential shift-and-add-3 (double-dabble) conversion, one bit per clock. It then drives N active-low seven-segment patterns in parallel. It sits between datapath results (sums, counters) and the board's static seven-segment displays. It succeeds the single-digit BCD decoder with arbitrary width, digit count, start/done handshake, overflow indication and optional leading-zero blanking.

## Interface
- W, 11: width of binary input; legal range 4..32.
- N, 4: number of displayed decimal digits; legal range 1..8.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- num  input  W  unsigned value to convert; sampled only on accepted start.
- start  input  1  conversion request; accepted only in IDLE.
- busy  output  1  high from the cycle after acceptance until done cycle inclusive.
- done  output  1  one-cycle pulse; seg and ovf carry new result in the same cycle.
- ovf  output  1  registered; high when the last converted num ≥ 10^N.
- seg  output  7*N  active-low segments {g,f,e,d,c,b,a}; digit 0 (units) in [6:0], digit k in [7k+6:7k].

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 captures num into shift register and clears BCD accumulator (4N bits, plus enough guard bits to flag overflow); bit counter = 0 → SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left 1; after W shifts → DONE.
  - DONE: register seg/ovf from accumulator, done=1 → IDLE.
- Decode per digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other nibble = error pattern 0011000.
- Overflow: num ≥ 10^N → ovf=1 and every digit shows error pattern 0011000; blanking not applied.
- start while busy is ignored; num changes while busy have no effect.
- seg/ovf hold their last values between conversions.
- rst in any state: FSM → IDLE, accumulator cleared, outputs to reset values; any in-flight conversion is discarded and never produces done.
- Reset values: busy=0, done=0, ovf=0, every digit 1000000 ("0"); with blanking, digit 0 = 1000000 and others = 1111111.

## Timing
- start sampled high at edge E (state IDLE) → busy=1 from E+1; W SHIFT cycles; DONE cycle begins at E+W+1 with done=1 and new seg/ovf visible.
- Total latency start→done: W+1 cycles; busy high W+1 cycles.
- Earliest next accepted start: cycle after done (back-to-back throughput = one conversion per W+2 cycles).
- start high on the done cycle is ignored (state is DONE, not IDLE).
- rst has priority over start in the same cycle.

## Configuration
- BIN7SEG_BLANK_EN defined: leading-zero blanking. Every digit above the most significant nonzero digit outputs 1111111. Digit 0 is never blanked, so value 0 shows a single "0". Applied at the DONE register update only.
- Undefined: all N digits always displayed, leading zeros shown as 1000000.
- Timing, handshake and overflow behaviour are identical in both builds.

## Test plan
- Reset: assert rst 2 cycles → busy=0, done=0, ovf=0, seg = all digits 1000000 (blank build: digit 0 = 1000000, others 1111111).
- W=11, N=4, num=2047, pulse start → done exactly 12 cycles later; digits 3..0 = 2,0,4,7 (0100100, 1000000, 0011001, 1111000), ovf=0.
- W=11, N=3, num=1000 → done after 12 cycles, ovf=1, all three digits 0011000; then num=999 → ovf=0, digits 9,9,9 (0010000).
- num=5 converting, re-pulse start with num=8 at cycle 3 of busy → ignored, result shows 5; busy length still W+1.
- rst at SHIFT cycle 5 of a conversion of 1234 → no done pulse, outputs return to reset values, next start with 42 converts correctly.
- BIN7SEG_BLANK_EN, N=4, num=7 → digit 0 = 1111000, digits 1..3 = 1111111; num=0 → digit 0 = 1000000, others blank.
